uriscv_muldiv_issue: RTL and testbench

Issue/retire sequencer that sits directly upstream and downstream of the M-extension multiply/divide unit.
- Accepts a decoded-stage request (instruction word plus two operands) from the execute stage.
- Decodes funct3 into the unit's one-hot op selects and drives a single-cycle valid.
- Waits for the unit's ready pulse, buffers the result and presents it to register-file writeback with a valid/ack handshake.
- Exposes busy and pending-rd status so the pipeline can interlock on the outstanding destination register.

---
 rtl/uriscv_defs_pkg.sv | 23 ++
 rtl/uriscv_muldiv_decode.sv | 36 +++
 rtl/uriscv_muldiv_issue.sv | 144 ++++++++++++++
 tb/tb_uriscv_muldiv_issue.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uriscv_defs_pkg.sv
// Shared encodings for the M-extension issue/retire sequencer.
package uriscv_defs;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_MUL     = 3'b000;
  localparam logic [2:0] F3_MULH    = 3'b001;
  localparam logic [2:0] F3_MULHSU  = 3'b010;
  localparam logic [2:0] F3_MULHU   = 3'b011;
  localparam logic [2:0] F3_DIV     = 3'b100;
  localparam logic [2:0] F3_DIVU    = 3'b101;
  localparam logic [2:0] F3_REM     = 3'b110;
  localparam logic [2:0] F3_REMU    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } md_state_e;

endpackage

// File: rtl/uriscv_muldiv_decode.sv
// Combinational M-op decode: recognises MUL/DIV/REM words and produces the
// unit's one-hot op select plus the destination register. Shared with the
// hazard logic, so it carries no state.
module uriscv_muldiv_decode
  import uriscv_defs::*;
(
  input  logic [31:0] inst,
  output logic        is_m,
  output logic [7:0]  onehot,
  output logic [4:0]  rd
);

  // rs1/rs2 fields are irrelevant here; operands arrive pre-read
  logic unused_fields;
  assign unused_fields = ^inst[24:15];

  assign is_m = (inst[6:0] == OPC_OP) && (inst[31:25] == F7_MULDIV);
  assign rd   = inst[11:7];

  // funct3 -> one-hot {remu,rem,divu,div,mulhu,mulhsu,mulh,mul}
  always_comb begin
    onehot = 8'b0;
    case (inst[14:12])
      F3_MUL:    onehot = 8'b0000_0001;
      F3_MULH:   onehot = 8'b0000_0010;
      F3_MULHSU: onehot = 8'b0000_0100;
      F3_MULHU:  onehot = 8'b0000_1000;
      F3_DIV:    onehot = 8'b0001_0000;
      F3_DIVU:   onehot = 8'b0010_0000;
      F3_REM:    onehot = 8'b0100_0000;
      F3_REMU:   onehot = 8'b1000_0000;
      default:   onehot = 8'b0;
    endcase
  end

endmodule

// File: rtl/uriscv_muldiv_issue.sv
// Issue/retire sequencer wrapped around the M-extension mul/div unit.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for a request; non-M words pulse decode_err_o
//   ST_ISSUE | md_valid_o high, held while the unit stalls
//   ST_WAIT  | waiting for md_ready_i; wait counter guards against hangs
//   ST_WB    | result presented to writeback until wb_ack_i
//
// All outputs are registered. The latched rd lives in pending_rd_o, which is
// zero whenever the sequencer is idle.
module uriscv_muldiv_issue
  import uriscv_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMO_W          = 7
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic [31:0] req_inst_i,
  input  logic [31:0] req_ra_i,
  input  logic [31:0] req_rb_i,
  output logic        req_accept_o,
  output logic        decode_err_o,
  output logic        md_valid_o,
  output logic [7:0]  md_inst_o,
  output logic [31:0] md_ra_o,
  output logic [31:0] md_rb_o,
  input  logic        md_stall_i,
  input  logic        md_ready_i,
  input  logic [31:0] md_result_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_value_o,
  input  logic        wb_ack_i,
  output logic        busy_o,
  output logic [4:0]  pending_rd_o,
  output logic        timeout_o
);

  // Last count value before the limit; reaching it ends the wait.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  md_state_e        state;
  logic [TMO_W-1:0] wait_cnt;
  logic             dec_is_m;
  logic [7:0]       dec_onehot;
  logic [4:0]       dec_rd;

  uriscv_muldiv_decode u_decode (
    .inst   (req_inst_i),
    .is_m   (dec_is_m),
    .onehot (dec_onehot),
    .rd     (dec_rd)
  );

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      req_accept_o <= 1'b0;
      decode_err_o <= 1'b0;
      md_valid_o   <= 1'b0;
      md_inst_o    <= '0;
      md_ra_o      <= '0;
      md_rb_o      <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= '0;
      wb_value_o   <= '0;
      busy_o       <= 1'b0;
      pending_rd_o <= '0;
      timeout_o    <= 1'b0;
    end else begin
      decode_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          req_accept_o <= 1'b1;
          if (req_accept_o && req_valid_i) begin
            if (dec_is_m) begin
              state        <= ST_ISSUE;
              req_accept_o <= 1'b0;
              busy_o       <= 1'b1;
              md_valid_o   <= 1'b1;
              md_inst_o    <= dec_onehot;
              md_ra_o      <= req_ra_i;
              md_rb_o      <= req_rb_i;
              pending_rd_o <= dec_rd;
            end else begin
              decode_err_o <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (!md_stall_i) begin
            state      <= ST_WAIT;
            md_valid_o <= 1'b0;
            md_inst_o  <= '0;
            wait_cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (md_ready_i) begin
            wait_cnt <= '0;
            if (pending_rd_o == 5'd0) begin
              // x0 destination: result is dropped, no writeback
              state        <= ST_IDLE;
              busy_o       <= 1'b0;
              req_accept_o <= 1'b1;
            end else begin
              state      <= ST_WB;
              wb_valid_o <= 1'b1;
              wb_rd_o    <= pending_rd_o;
              wb_value_o <= md_result_i;
            end
          end else if (wait_cnt == TMO_LAST) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            timeout_o    <= 1'b1;
            busy_o       <= 1'b0;
            pending_rd_o <= '0;
            req_accept_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WB: begin
          if (wb_ack_i) begin
            state        <= ST_IDLE;
            wb_valid_o   <= 1'b0;
            wb_rd_o      <= '0;
            wb_value_o   <= '0;
            busy_o       <= 1'b0;
            pending_rd_o <= '0;
            req_accept_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uriscv_muldiv_issue.sv
// Directed bench for the mul/div issue sequencer: a behavioural unit model
// answers issues, a scoreboard queue holds hand-computed writebacks, and a
// monitor compares whenever wb_valid_o is presented.
module tb_uriscv_muldiv_issue;

  logic        clk_i, rst_ni;
  logic        req_valid_i;
  logic [31:0] req_inst_i, req_ra_i, req_rb_i;
  logic        req_accept_o, decode_err_o, md_valid_o;
  logic [7:0]  md_inst_o;
  logic [31:0] md_ra_o, md_rb_o;
  logic        md_stall_i, md_ready_i;
  logic [31:0] md_result_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_value_o;
  logic        wb_ack_i, busy_o, timeout_o;
  logic [4:0]  pending_rd_o;

  uriscv_muldiv_issue #(.TIMEOUT_CYCLES(64), .TMO_W(7)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_inst_i(req_inst_i),
    .req_ra_i(req_ra_i), .req_rb_i(req_rb_i),
    .req_accept_o(req_accept_o), .decode_err_o(decode_err_o),
    .md_valid_o(md_valid_o), .md_inst_o(md_inst_o),
    .md_ra_o(md_ra_o), .md_rb_o(md_rb_o),
    .md_stall_i(md_stall_i), .md_ready_i(md_ready_i), .md_result_i(md_result_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_value_o(wb_value_o),
    .wb_ack_i(wb_ack_i), .busy_o(busy_o), .pending_rd_o(pending_rd_o),
    .timeout_o(timeout_o)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] value;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ack_hold = 0;
  bit   no_ready = 0;
  bit   in_wb = 0;
  int   wb_rises = 0;
  int   n_issue = 0;
  int   valid_cycles = 0;

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  // Behavioural stand-in for the mul/div unit
  function automatic logic [31:0] unit_calc(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0] up;
    logic [31:0] r;
    r = 32'h0;
    case (op)
      8'h01: begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
      8'h02: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = sp[63:32]; end
      8'h04: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = sp[63:32]; end
      8'h08: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      8'h10: r = (b == 0) ? 32'hFFFFFFFF : 32'($signed(a) / $signed(b));
      8'h20: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      8'h40: r = (b == 0) ? a : 32'($signed(a) % $signed(b));
      8'h80: r = (b == 0) ? a : a % b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Unit model: takes an issue on a non-stalled valid cycle, answers later
  initial begin
    int lat;
    logic [31:0] res;
    md_ready_i  = 0;
    md_result_i = 32'hDEADBEEF;
    forever begin
      @(negedge clk_i);
      if (md_valid_o && !md_stall_i) begin
        n_issue++;
        if (!no_ready) begin
          lat = (md_inst_o[7:4] != 4'b0) ? 35 : 3;
          res = unit_calc(md_inst_o, md_ra_o, md_rb_o);
          repeat (lat - 1) @(negedge clk_i);
          md_ready_i  = 1;
          md_result_i = res;
          @(negedge clk_i);
          md_ready_i  = 0;
          md_result_i = 32'hDEADBEEF;
        end
      end
    end
  end

  // Writeback acknowledger with programmable hold-off
  initial begin
    wb_ack_i = 0;
    forever begin
      @(negedge clk_i);
      if (wb_valid_o && !wb_ack_i) begin
        repeat (ack_hold) @(negedge clk_i);
        wb_ack_i = 1;
        @(negedge clk_i);
        wb_ack_i = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on each new writeback, checks hold while valid
  always @(negedge clk_i) begin
    if (md_valid_o) valid_cycles++;
    if (wb_valid_o) begin
      if (!in_wb) begin
        in_wb = 1;
        wb_rises++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wb_unexpected: got rd %0d value %0h want no writeback", wb_rd_o, wb_value_o);
        end else begin
          cur = sb.pop_front();
          check("wb_rd", wb_rd_o, cur.rd);
          check("wb_value", wb_value_o, cur.value);
          check("wb_latency", cyc, cur.cyc);
        end
      end else begin
        check("wb_rd_hold", wb_rd_o, cur.rd);
        check("wb_value_hold", wb_value_o, cur.value);
      end
    end else begin
      in_wb = 0;
    end
  end

  task automatic issue(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b, output int acc);
    int n = 0;
    @(negedge clk_i);
    while (!req_accept_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("accept_wait", req_accept_o, 1);
    req_valid_i = 1;
    req_inst_i  = inst;
    req_ra_i    = a;
    req_rb_i    = b;
    @(posedge clk_i);
    #1;
    acc = cyc;
    req_valid_i = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_i);
    while ((busy_o || wb_valid_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("idle_wait", {busy_o, wb_valid_o}, 2'b00);
  endtask

  function automatic logic [127:0] all_outs();
    return {req_accept_o, decode_err_o, md_valid_o, md_inst_o, md_ra_o, md_rb_o,
            wb_valid_o, wb_rd_o, wb_value_o, busy_o, pending_rd_o, timeout_o};
  endfunction

  initial begin
    int acc, n, i0, v0, r0;
    rst_ni = 1; req_valid_i = 0; req_inst_i = 0; req_ra_i = 0; req_rb_i = 0; md_stall_i = 0;
    #1 rst_ni = 0;
    #11;
    check("reset_outputs", all_outs(), 128'h0);
    @(negedge clk_i); rst_ni = 1;
    @(negedge clk_i);
    check("accept_after_reset", {req_accept_o, busy_o}, 2'b10);

    // MUL x5 = 7*6, writeback held 4 extra cycles
    ack_hold = 4;
    issue(rtype(7'h01, 3'b000, 5'd5), 32'd7, 32'd6, acc);
    sb.push_back('{5'd5, 32'd42, acc + 3});
    @(negedge clk_i);
    check("mul_issue", {md_valid_o, md_inst_o, md_ra_o, md_rb_o, busy_o, pending_rd_o},
          {1'b1, 8'h01, 32'd7, 32'd6, 1'b1, 5'd5});
    @(negedge clk_i);
    check("mul_valid_drop", md_valid_o, 0);
    wait_idle();
    ack_hold = 0;

    // DIV x3 = -20/3; status must hold for the whole operation
    issue(rtype(7'h01, 3'b100, 5'd3), 32'hFFFFFFEC, 32'd3, acc);
    sb.push_back('{5'd3, 32'hFFFFFFFA, acc + 35});
    n = 0;
    @(negedge clk_i);
    while (!wb_valid_o && n < 60) begin
      check("div_busy_rd", {busy_o, pending_rd_o}, {1'b1, 5'd3});
      @(negedge clk_i);
      n++;
    end
    check("div_wb_status", {busy_o, pending_rd_o, wb_valid_o}, {1'b1, 5'd3, 1'b1});
    wait_idle();

    // REM x3 = -20 % 3
    issue(rtype(7'h01, 3'b110, 5'd3), 32'hFFFFFFEC, 32'd3, acc);
    sb.push_back('{5'd3, 32'hFFFFFFFE, acc + 35});
    @(negedge clk_i);
    check("rem_onehot", md_inst_o, 8'h40);
    wait_idle();

    // Stall in ISSUE: valid and op held, exactly one issue taken
    i0 = n_issue; v0 = valid_cycles;
    md_stall_i = 1;
    issue(rtype(7'h01, 3'b000, 5'd10), 32'd11, 32'd13, acc);
    sb.push_back('{5'd10, 32'd143, acc + 8});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("stall_hold", {md_valid_o, md_inst_o, md_ra_o}, {1'b1, 8'h01, 32'd11});
    end
    @(posedge clk_i); #1 md_stall_i = 0;
    wait_idle();
    check("stall_single_issue", n_issue - i0, 1);
    check("stall_valid_cycles", valid_cycles - v0, 6);

    // MULHU to x0: result discarded, back to IDLE right after ready
    r0 = wb_rises;
    issue(rtype(7'h01, 3'b011, 5'd0), 32'hFFFFFFFF, 32'hFFFFFFFF, acc);
    n = 0;
    do begin
      @(posedge clk_i);
      n++;
    end while (!md_ready_i && n < 20);
    @(negedge clk_i);
    check("rd0_idle", {busy_o, pending_rd_o, wb_valid_o, req_accept_o}, {1'b0, 5'd0, 1'b0, 1'b1});
    repeat (3) @(negedge clk_i);
    check("rd0_no_wb", wb_rises - r0, 0);

    // ADD: decode error pulse, nothing issued
    i0 = n_issue; v0 = valid_cycles;
    issue({7'h00, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011}, 32'd1, 32'd2, acc);
    @(negedge clk_i);
    check("add_decode_err", {decode_err_o, busy_o, md_valid_o}, 3'b100);
    @(negedge clk_i);
    check("add_err_pulse", decode_err_o, 0);
    repeat (4) @(negedge clk_i);
    check("add_no_issue", {n_issue - i0, valid_cycles - v0}, 64'h0);

    // Withheld ready: timeout after 1 issue cycle + 64 wait cycles
    no_ready = 1;
    issue(rtype(7'h01, 3'b100, 5'd4), 32'd100, 32'd5, acc);
    repeat (65) @(negedge clk_i);
    check("tmo_before", {timeout_o, busy_o, cyc}, {1'b0, 1'b1, 32'(acc + 64)});
    @(negedge clk_i);
    check("tmo_set", {timeout_o, busy_o, pending_rd_o, wb_valid_o}, {1'b1, 1'b0, 5'd0, 1'b0});
    repeat (3) @(negedge clk_i);
    check("tmo_sticky", timeout_o, 1);
    no_ready = 0;

    // Asynchronous reset in the middle of a DIV
    r0 = wb_rises;
    issue(rtype(7'h01, 3'b100, 5'd9), 32'd100, 32'd7, acc);
    repeat (10) @(negedge clk_i);
    #2 rst_ni = 0;
    #1;
    check("async_reset_outputs", all_outs(), 128'h0);
    @(negedge clk_i); rst_ni = 1;
    repeat (45) @(negedge clk_i);
    check("reset_no_wb", {wb_rises - r0, busy_o, timeout_o}, {32'd0, 1'b0, 1'b0});
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion want finish by 100000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
